// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle RV32 shift unit (SLL/SRL/SRA/ROR).
// A request is accepted in IDLE. The operand is shifted by at most STEP bits
// per cycle, and the result is returned together with a one-cycle done pulse.
// Ports:
//   clk_i, rst_i        clock and synchronous active-high reset
//   start_i             request strobe; sampled only while ready_o=1
//   op_i                00 SLL, 01 SRL, 10 SRA, 11 ROR
//   value_i, shamt_i    operand and shift amount, captured on accept
//   flush_i             abort the current operation; has priority over start_i
//   ready_o             high in IDLE
//   busy_o              high in SHIFT and DONE
//   done_o              one-cycle pulse; value_o is valid in the same cycle
//   value_o             result register; holds the last completed result
module shift_sequencer #(
   parameter int unsigned STEP = 1   // legal values: 1, 2, 4, 8, 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [1:0]  op_i,
   input  logic [31:0] value_i,
   input  logic [4:0]  shamt_i,
   input  logic        flush_i,
   output logic        ready_o,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] value_o
);

   localparam int unsigned W  = 32;
   localparam int unsigned AW = 5;
   localparam logic [AW-1:0] STEP_AMT = AW'(STEP);

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROR = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [W-1:0]    work_q, work_d;
   logic [AW-1:0]   rem_q, rem_d;
   logic [1:0]      op_q, op_d;
   logic [W-1:0]    value_q, value_d;
   logic            ready_q, ready_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic [AW-1:0]   k_c;
   logic [AW-1:0]   rem_next_c;
   logic [W-1:0]    shifted_c;

   // One shift step of at most STEP bits; k is never zero while in SHIFT.
   function automatic logic [W-1:0] shift_step(input logic [W-1:0] w,
                                               input logic [1:0]   op,
                                               input logic [AW-1:0] k);
      logic [2*W-1:0] dbl;
      logic [W-1:0]   res;
      dbl = {w, w} >> k;
      case (op)
         OP_SLL:  res = w << k;
         OP_SRL:  res = w >> k;
         OP_SRA:  res = W'($signed(w) >>> k);
         OP_ROR:  res = dbl[W-1:0];
         default: res = w;
      endcase
      return res;
   endfunction

   // Step size and shifted operand for the current SHIFT cycle.
   always_comb begin
      k_c        = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
      rem_next_c = rem_q - k_c;
      shifted_c  = shift_step(work_q, op_q, k_c);
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      rem_d   = rem_q;
      op_d    = op_q;
      value_d = value_q;

      case (state_q)
         S_IDLE: begin
            if (start_i && !flush_i) begin
               work_d = value_i;
               rem_d  = shamt_i;
               op_d   = op_i;
               if (shamt_i == '0) begin
                  state_d = S_DONE;
                  value_d = value_i;
               end else begin
                  state_d = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            work_d = shifted_c;
            rem_d  = rem_next_c;
            if (rem_next_c == '0) begin
               state_d = S_DONE;
               value_d = shifted_c;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Flush aborts without publishing a result.
      if (flush_i) begin
         state_d = S_IDLE;
         value_d = value_q;
      end

      ready_d = (state_d == S_IDLE);
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
   end

   // State and data registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         work_q  <= '0;
         rem_q   <= '0;
         op_q    <= '0;
         value_q <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         rem_q   <= rem_d;
         op_q    <= op_d;
         value_q <= value_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign ready_o = ready_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;
   assign value_o = value_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer: runs a STEP=1 and a STEP=4 instance in
// lockstep on shared inputs and checks both against a reference model.
module tb_shift_sequencer;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [1:0]  op_i;
   logic [31:0] value_i;
   logic [4:0]  shamt_i;
   logic        flush_i;

   logic        r1, b1, d1;
   logic [31:0] v1;
   logic        r4, b4, d4;
   logic [31:0] v4;

   int n_assert = 0;
   int n_fail   = 0;
   logic [31:0] prev_val;

   always #5 clk = ~clk;

   shift_sequencer #(.STEP(1)) u_s1 (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
      .value_i(value_i), .shamt_i(shamt_i), .flush_i(flush_i),
      .ready_o(r1), .busy_o(b1), .done_o(d1), .value_o(v1)
   );

   shift_sequencer #(.STEP(4)) u_s4 (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
      .value_i(value_i), .shamt_i(shamt_i), .flush_i(flush_i),
      .ready_o(r4), .busy_o(b4), .done_o(d4), .value_o(v4)
   );

   // Full-distance result computed in one go from the operation definition.
   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] v, input int s);
      logic [31:0] r;
      r = v;
      case (op)
         2'b00: r = v << s;
         2'b01: r = v >> s;
         2'b10: r = 32'($signed(v) >>> s);
         default: for (int i = 0; i < s; i++) r = {r[0], r[31:1]};
      endcase
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag, input logic [31:0] val);
      check({tag, "_ready1"}, 32'(r1), 32'd1);
      check({tag, "_busy1"},  32'(b1), 32'd0);
      check({tag, "_done1"},  32'(d1), 32'd0);
      check({tag, "_value1"}, v1, val);
      check({tag, "_ready4"}, 32'(r4), 32'd1);
      check({tag, "_busy4"},  32'(b4), 32'd0);
      check({tag, "_done4"},  32'(d4), 32'd0);
      check({tag, "_value4"}, v4, val);
   endtask

   // Issue one request; optionally pulse a foreign start_i in cycle 'poke'.
   task automatic run_op(input logic [1:0] op, input logic [31:0] v, input int s, input int poke);
      logic [31:0] exp;
      int lat1, lat4, lmax;
      exp  = model(op, v, s);
      lat1 = 1 + s;
      lat4 = 1 + (s + 3) / 4;
      lmax = ((lat1 > lat4) ? lat1 : lat4) + 1;
      @(negedge clk);
      start_i = 1'b1; op_i = op; value_i = v; shamt_i = 5'(s);
      @(posedge clk); #1;
      start_i = 1'b0;
      for (int c = 1; c <= lmax; c++) begin
         check("done1",  32'(d1), 32'(c == lat1));
         check("busy1",  32'(b1), 32'(c <= lat1));
         check("ready1", 32'(r1), 32'(c >  lat1));
         check("value1", v1, (c >= lat1) ? exp : prev_val);
         check("done4",  32'(d4), 32'(c == lat4));
         check("busy4",  32'(b4), 32'(c <= lat4));
         check("ready4", 32'(r4), 32'(c >  lat4));
         check("value4", v4, (c >= lat4) ? exp : prev_val);
         if (c == poke) begin
            start_i = 1'b1; op_i = ~op; value_i = ~v; shamt_i = 5'd7;
         end else begin
            start_i = 1'b0;
         end
         @(posedge clk); #1;
      end
      start_i = 1'b0;
      prev_val = exp;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0;
      op_i = '0; value_i = '0; shamt_i = '0;
      prev_val = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst_i = 1'b0;
      check_idle("reset", 32'h0);

      // Directed cases from the plan.
      run_op(2'b01, 32'h8000_0000, 31, 0);
      run_op(2'b10, 32'h8000_0000, 4, 0);
      run_op(2'b10, 32'h7000_0000, 4, 0);
      run_op(2'b00, 32'h0000_000F, 0, 0);
      run_op(2'b11, 32'h0000_00F1, 4, 0);
      run_op(2'b00, 32'h0000_0001, 31, 0);

      // start_i pulsed while shifting must be ignored.
      run_op(2'b11, 32'h1234_5678, 31, 3);

      // Flush in cycle 3 of a 31-cycle op.
      @(negedge clk);
      start_i = 1'b1; op_i = 2'b01; value_i = 32'hDEAD_BEEF; shamt_i = 5'd31;
      @(posedge clk); #1;
      start_i = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         check("flush_busy1", 32'(b1), 32'd1);
         check("flush_busy4", 32'(b4), 32'd1);
         if (c == 3) flush_i = 1'b1;
         @(posedge clk); #1;
      end
      flush_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check_idle("flush", prev_val);
         @(posedge clk); #1;
      end

      // Reset mid-operation.
      @(negedge clk);
      start_i = 1'b1; op_i = 2'b00; value_i = 32'hCAFE_F00D; shamt_i = 5'd29;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      rst_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      prev_val = 32'h0;
      check_idle("midrst", 32'h0);

      // Simultaneous start_i and flush_i in IDLE is not accepted.
      @(negedge clk);
      start_i = 1'b1; flush_i = 1'b1; op_i = 2'b00; value_i = 32'h5; shamt_i = 5'd0;
      @(posedge clk); #1;
      start_i = 1'b0; flush_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check_idle("stflush", prev_val);
         @(posedge clk); #1;
      end

      // Randomized operations.
      for (int i = 0; i < 30; i++) begin
         logic [1:0]  rop;
         logic [31:0] rv;
         int          rs;
         rop = 2'($urandom_range(0, 3));
         rv  = $urandom;
         rs  = $urandom_range(0, 31);
         run_op(rop, rv, rs, (rs > 8 && $urandom_range(0, 1) == 1) ? 2 : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift unit controller for the RV32 execute stage. It accepts one shift request (SLL/SRL/SRA/ROR, 5-bit amount), iterates a fixed-step shift stage over several cycles, and returns the 32-bit result with a one-cycle done pulse. It trades a full barrel shifter for latency and lets the hazard unit stall on `busy_o`.

## Interface
- `STEP`, default 1: maximum shift distance applied per cycle. Legal values are 1, 2, 4, 8 and 16.
- `clk_i` input 1: clock. All state changes on the rising edge.
- `rst_i` input 1: synchronous reset, active-high.
- `start_i` input 1: request strobe. Sampled only while `ready_o`=1.
- `op_i` input 2: operation code. 00 = SLL, 01 = SRL, 10 = SRA, 11 = ROR (rotate right).
- `value_i` input 32: operand, captured on accept.
- `shamt_i` input 5: shift amount 0..31, captured on accept.
- `flush_i` input 1: abort the current operation (pipeline flush).
- `ready_o` output 1: high in IDLE. A request may be accepted.
- `busy_o` output 1: high in SHIFT and DONE.
- `done_o` output 1: one-cycle pulse when `value_o` becomes valid.
- `value_o` output 32: result register. Holds the last completed result.

## Operation
- State machine: IDLE, SHIFT, DONE. Encoding is free.
- Internal registers: `work` (32 bits), `rem` (5 bits), `op_q` (2 bits).
- IDLE:
  - On `start_i`=1 and `flush_i`=0: `work`<=`value_i`, `rem`<=`shamt_i`, `op_q`<=`op_i`.
  - Go to SHIFT if `shamt_i`≠0, else go to DONE.
- SHIFT, every cycle:
  - k = min(STEP, `rem`). Apply k-bit shift of `op_q` to `work`. `rem`<=`rem`−k.
  - When `rem`−k = 0, go to DONE.
  - Shift semantics:
    - SLL: fill zeros at the LSBs.
    - SRL: fill zeros at the MSBs.
    - SRA: fill copies of `work[31]` at the MSBs.
    - ROR: bits leaving bit 0 re-enter at bit 31.
- DONE: `done_o`=1 for exactly this cycle, then go to IDLE unconditionally.
- `value_o`: loaded from the final `work` on the edge that enters DONE. Held unchanged at all other times, including during later operations.
- `start_i` outside IDLE is ignored. There is no queueing; the requester must hold or re-issue it.
- `flush_i`=1 in any state: go to IDLE next edge. No `done_o`, `value_o` unchanged. `flush_i` has priority over `start_i` in IDLE.
- Reset mid-operation behaves like flush, but also clears `value_o`.
- `rem` arithmetic is unsigned 5-bit. k ≤ `rem` always holds, so there is no underflow or wrap.

## Timing
- Reset values:
  - State = IDLE.
  - `ready_o`=1, `busy_o`=0, `done_o`=0.
  - `value_o`=0x00000000. `work`, `rem` and `op_q` are cleared to 0.
- Accept edge = edge E0, where `start_i`=1 and `ready_o`=1.
- `done_o` is high in cycle 1 + ceil(`shamt_i`/STEP) after E0.
  - shamt=0 gives `done_o` in cycle 1.
  - STEP=1 with shamt=31 gives `done_o` in cycle 32.
- `value_o` is valid in the same cycle as `done_o`.
- `ready_o` returns high in the cycle after `done_o`. Back-to-back throughput is one operation per (latency+1) cycles.
- Outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Test plan
- STEP=1, SRL, `value_i`=0x80000000, shamt=31:
  - `busy_o` high for 32 cycles.
  - `done_o` in cycle 32 with `value_o`=0x00000001.
- STEP=1, SRA, 0x80000000, shamt=4:
  - `done_o` in cycle 5 with `value_o`=0xF8000000.
  - Repeat with 0x70000000: 0x07000000.
- STEP=4, SLL, 0x0000000F, shamt=0:
  - `done_o` in cycle 1 with `value_o`=0x0000000F, skipping SHIFT.
- STEP=4, ROR, 0x000000F1, shamt=4: `done_o` in cycle 2 with 0x1000000F.
- STEP=4, SLL, 0x00000001, shamt=31:
  - Per-cycle k = 4,4,4,4,4,4,4,3.
  - `done_o` in cycle 9 with 0x80000000.
- Control boundaries (one case per line):
  - `start_i` pulsed during SHIFT: ignored, and the first result is correct.
  - `flush_i` in cycle 3 of a 31-cycle op: IDLE next cycle, no `done_o`, `value_o` keeps its prior value.
  - `rst_i` mid-op: all outputs return to their reset values on the next edge.
  - Simultaneous `start_i` and `flush_i` in IDLE: not accepted.
